axis_packet_fifo: RTL and testbench

Parametrised AXI-Stream FIFO for the arbiter datapath: buffers beats (data, id, last) between an upstream master and a downstream slave, generalised in data width, id width and depth. Optional packet (store-and-forward) mode holds a packet back until its last beat is stored, so packets reach the arbiter without bubbles. Also reports fill level and stored packet count, and flags an id change inside a packet.

---
 rtl/axis_packet_fifo.sv | 119 +++++++++++
 tb/tb_axis_packet_fifo.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_fifo.sv
// AXI-Stream beat FIFO with optional store-and-forward packet mode.
// Also reports fill level and stored packet count, and flags an id change inside a packet.
module axis_packet_fifo #(
    parameter int DATA_SIZE   = 32,
    parameter int ID_SIZE     = 8,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0
) (
    input  logic                      aclk,
    input  logic                      areset_n,
    input  logic                      s_t_valid,
    output logic                      s_t_ready,
    input  logic                      s_t_last,
    input  logic [DATA_SIZE-1:0]      s_t_data,
    input  logic [ID_SIZE-1:0]        s_t_id,
    output logic                      m_t_valid,
    input  logic                      m_t_ready,
    output logic                      m_t_last,
    output logic [DATA_SIZE-1:0]      m_t_data,
    output logic [ID_SIZE-1:0]        m_t_id,
    output logic [$clog2(DEPTH):0]    fill_level,
    output logic [$clog2(DEPTH):0]    pkt_count,
    output logic                      id_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_SIZE + ID_SIZE + 1;
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [EW-1:0]      mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [AW:0]        pkt_cnt_q;
    logic               ready_en;
    logic               in_pkt;
    logic [ID_SIZE-1:0] cur_id;
    logic               full;
    logic               empty;
    logic               wr_en;
    logic               rd_en;
    logic               out_valid;
    logic [EW-1:0]      rd_entry;

    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        s_t_ready = !full && ready_en;
        wr_en     = s_t_valid && s_t_ready;
        rd_entry  = mem[rd_ptr[AW-1:0]];
    end

    // In packet mode a full FIFO releases beats anyway so an oversize packet cannot deadlock.
    always_comb begin
        out_valid = !empty;
        if (PACKET_MODE != 0) begin
            out_valid = !empty && ((pkt_cnt_q != '0) || full);
        end
    end

    always_comb begin
        rd_en      = out_valid && m_t_ready;
        m_t_valid  = out_valid;
        {m_t_last, m_t_id, m_t_data} = out_valid ? rd_entry : '0;
        fill_level = wr_ptr - rd_ptr;
        pkt_count  = pkt_cnt_q;
    end

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {s_t_last, s_t_id, s_t_data};
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            pkt_cnt_q <= '0;
        end else begin
            unique case ({wr_en && s_t_last, rd_en && rd_entry[EW-1]})
                2'b10:   pkt_cnt_q <= pkt_cnt_q + PTR_ONE;
                2'b01:   pkt_cnt_q <= pkt_cnt_q - PTR_ONE;
                default: pkt_cnt_q <= pkt_cnt_q;
            endcase
        end
    end

    // cur_id keeps the first beat's id for the whole packet, so a stray id is flagged but never adopted.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            in_pkt <= 1'b0;
            cur_id <= '0;
            id_err <= 1'b0;
        end else begin
            id_err <= wr_en && in_pkt && (s_t_id != cur_id);
            if (wr_en) begin
                if (!in_pkt) begin
                    cur_id <= s_t_id;
                end
                in_pkt <= !s_t_last;
            end
        end
    end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Bench for axis_packet_fifo: a cut-through DEPTH=16 instance and a packet-mode DEPTH=8 instance,
// each checked every cycle against a queue-based reference of the FIFO's observable behaviour.
module tb_axis_packet_fifo;

    typedef struct packed {
        logic        last;
        logic [7:0]  id;
        logic [31:0] data;
    } beat_t;

    logic        aclk = 1'b0;
    logic        areset_n;
    logic        s_valid [2];
    logic        s_last  [2];
    logic [31:0] s_data  [2];
    logic [7:0]  s_id    [2];
    logic        m_ready [2];
    logic        s_ready [2];
    logic        m_valid [2];
    logic        m_last  [2];
    logic [31:0] m_data  [2];
    logic [7:0]  m_id    [2];
    logic        id_err  [2];
    logic [4:0]  fill0, pkt0;
    logic [3:0]  fill1, pkt1;
    logic        en_m = 1'b0;
    bit          rand_rdy = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 aclk = ~aclk;

    axis_packet_fifo #(.DATA_SIZE(32), .ID_SIZE(8), .DEPTH(16), .PACKET_MODE(0)) u_ct (
        .aclk(aclk), .areset_n(areset_n),
        .s_t_valid(s_valid[0]), .s_t_ready(s_ready[0]), .s_t_last(s_last[0]),
        .s_t_data(s_data[0]), .s_t_id(s_id[0]),
        .m_t_valid(m_valid[0]), .m_t_ready(m_ready[0]), .m_t_last(m_last[0]),
        .m_t_data(m_data[0]), .m_t_id(m_id[0]),
        .fill_level(fill0), .pkt_count(pkt0), .id_err(id_err[0])
    );

    axis_packet_fifo #(.DATA_SIZE(32), .ID_SIZE(8), .DEPTH(8), .PACKET_MODE(1)) u_pm (
        .aclk(aclk), .areset_n(areset_n),
        .s_t_valid(s_valid[1]), .s_t_ready(s_ready[1]), .s_t_last(s_last[1]),
        .s_t_data(s_data[1]), .s_t_id(s_id[1]),
        .m_t_valid(m_valid[1]), .m_t_ready(m_ready[1]), .m_t_last(m_last[1]),
        .m_t_data(m_data[1]), .m_t_id(m_id[1]),
        .fill_level(fill1), .pkt_count(pkt1), .id_err(id_err[1])
    );

    // Input acceptance is possible from the first edge after reset release.
    always @(posedge aclk) en_m <= areset_n;

    function automatic void chk(input int g, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL u%0d %s: got %0h expected %0h at %0t", g, nm, act, exp, $time);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int DEP  = (g == 0) ? 16 : 8;
        localparam bit PKTM = (g == 1);
        beat_t       q[$];
        logic        in_pkt  = 1'b0;
        logic [7:0]  cur_id  = '0;
        logic        err_exp = 1'b0;
        logic        stall   = 1'b0;
        beat_t       held    = '0;

        always @(negedge aclk) begin
            beat_t outb;
            int    lasts;
            int    fill_v;
            int    pkt_v;
            logic  exp_v;
            logic  wr;
            logic  rd;
            outb   = {m_last[g], m_id[g], m_data[g]};
            fill_v = (g == 0) ? int'(fill0) : int'(fill1);
            pkt_v  = (g == 0) ? int'(pkt0) : int'(pkt1);
            lasts  = 0;
            foreach (q[j]) if (q[j].last) lasts++;
            if (!areset_n) begin
                q.delete();
                in_pkt  = 1'b0;
                cur_id  = '0;
                err_exp = 1'b0;
                stall   = 1'b0;
                chk(g, "rst_s_ready", 64'(s_ready[g]), 64'd0);
                chk(g, "rst_m_valid", 64'(m_valid[g]), 64'd0);
                chk(g, "rst_m_beat", 64'(outb), 64'd0);
                chk(g, "rst_fill", 64'(fill_v), 64'd0);
                chk(g, "rst_pkt", 64'(pkt_v), 64'd0);
                chk(g, "rst_id_err", 64'(id_err[g]), 64'd0);
            end else begin
                exp_v = (q.size() > 0) && (!PKTM || lasts > 0 || q.size() == DEP);
                chk(g, "s_ready", 64'(s_ready[g]), 64'(en_m && q.size() < DEP));
                chk(g, "m_valid", 64'(m_valid[g]), 64'(exp_v));
                chk(g, "fill_level", 64'(fill_v), 64'(q.size()));
                chk(g, "pkt_count", 64'(pkt_v), 64'(lasts));
                chk(g, "id_err", 64'(id_err[g]), 64'(err_exp));
                if (stall) chk(g, "hold_stable", 64'(outb), 64'(held));
                if (m_valid[g]) begin
                    chk(g, "beat_available", 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) chk(g, "beat", 64'(outb), 64'(q[0]));
                end else begin
                    chk(g, "idle_outputs_zero", 64'(outb), 64'd0);
                end
                stall = m_valid[g] && !m_ready[g];
                held  = outb;
                wr = s_valid[g] && s_ready[g];
                rd = m_valid[g] && m_ready[g];
                err_exp = wr && in_pkt && (s_id[g] != cur_id);
                if (wr) begin
                    if (!in_pkt) cur_id = s_id[g];
                    in_pkt = !s_last[g];
                end
                if (rd && q.size() != 0) void'(q.pop_front());
                if (wr) q.push_back({s_last[g], s_id[g], s_data[g]});
            end
        end
    end

    task automatic step(input int i);
        @(posedge aclk);
        #1;
        if (rand_rdy) m_ready[i] = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_accept(input int i);
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge aclk);
            ok = s_ready[i];
            step(i);
        end
        chk(i, "accept_in_time", 64'(ok), 64'd1);
    endtask

    task automatic send(input int i, input logic [31:0] d, input logic [7:0] id, input logic last);
        s_valid[i] = 1'b1;
        s_data[i]  = d;
        s_id[i]    = id;
        s_last[i]  = last;
        wait_accept(i);
    endtask

    task automatic idle(input int i, input int n);
        s_valid[i] = 1'b0;
        repeat (n) step(i);
    endtask

    task automatic wait_drain(input int i);
        int left;
        s_valid[i] = 1'b0;
        left = (i == 0) ? mon[0].q.size() : mon[1].q.size();
        for (int t = 0; t < 3000 && left != 0; t++) begin
            step(i);
            left = (i == 0) ? mon[0].q.size() : mon[1].q.size();
        end
        step(i);
        chk(i, "drained_in_time", 64'(left), 64'd0);
    endtask

    task automatic run_random(input int i, input int nbeats, input int maxlen);
        int         sent;
        int         len;
        logic [7:0] id;
        logic [7:0] bid;
        sent = 0;
        while (sent < nbeats) begin
            len = $urandom_range(1, maxlen);
            id  = 8'($urandom_range(0, 3));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) idle(i, 1);
                bid = ($urandom_range(0, 15) == 0) ? (id ^ 8'h01) : id;
                send(i, $urandom, bid, k == len - 1);
                sent++;
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_valid[i] = 1'b0;
            s_last[i]  = 1'b0;
            s_data[i]  = '0;
            s_id[i]    = '0;
            m_ready[i] = 1'b0;
        end
        #1 areset_n = 1'b0;
        repeat (3) @(posedge aclk);
        #2 areset_n = 1'b1;
        step(0);
        step(0);

        // Cut-through: four beats straight through.
        m_ready[0] = 1'b1;
        for (int k = 1; k <= 4; k++) send(0, 32'(k), 8'h05, k == 4);
        wait_drain(0);

        // Fill to full, hold a 17th beat, release one slot with a single-cycle ready.
        m_ready[0] = 1'b0;
        for (int k = 0; k < 16; k++) send(0, 32'h100 + 32'(k), 8'h10, (k % 4) == 3);
        s_valid[0] = 1'b1;
        s_data[0]  = 32'h200;
        s_id[0]    = 8'h11;
        s_last[0]  = 1'b1;
        repeat (3) step(0);
        m_ready[0] = 1'b1;
        step(0);
        m_ready[0] = 1'b0;
        wait_accept(0);
        s_valid[0] = 1'b0;
        repeat (2) step(0);
        m_ready[0] = 1'b1;
        wait_drain(0);

        // id change inside a packet, then a clean packet on the new id.
        send(0, 32'hA1, 8'h03, 1'b0);
        send(0, 32'hA2, 8'h03, 1'b0);
        send(0, 32'hA3, 8'h07, 1'b1);
        send(0, 32'hB1, 8'h07, 1'b0);
        send(0, 32'hB2, 8'h07, 1'b1);
        wait_drain(0);

        // Packet mode: 5-beat packet with idle cycles between beats.
        m_ready[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) idle(1, 1);
            send(1, 32'h300 + 32'(k), 8'h21, k == 4);
        end
        wait_drain(1);

        // Packet mode: 12-beat packet into an 8-deep FIFO.
        for (int k = 0; k < 12; k++) send(1, 32'h400 + 32'(k), 8'h22, k == 11);
        wait_drain(1);

        rand_rdy = 1'b1;
        run_random(1, 1500, 12);
        wait_drain(1);

        run_random(0, 5000, 6);
        for (int k = 0; k < 3; k++) send(0, $urandom, 8'h02, 1'b0);
        idle(0, 1);
        #1 areset_n = 1'b0;
        repeat (2) @(posedge aclk);
        #2 areset_n = 1'b1;
        step(0);
        run_random(0, 5000, 6);
        wait_drain(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
